// File: rtl/nios_sys_pio_pkg.sv
// Shared types and bus idle constants for the nios_sys PIO initiator.
package nios_sys_pio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_VERIFY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Command field widths; the initiator's ADDR_W/DATA_W defaults follow these.
  localparam int CMD_ADDR_W = 2;
  localparam int CMD_DATA_W = 32;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] address;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic                  BUS_IDLE_CS      = 1'b0;
  localparam logic                  BUS_IDLE_WRITE_N = 1'b1;
  localparam logic [CMD_ADDR_W-1:0] BUS_IDLE_ADDR    = '0;
  localparam logic [CMD_DATA_W-1:0] BUS_IDLE_WDATA   = '0;

endpackage

// File: rtl/nios_sys_pio_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by the MSB alone.
module nios_sys_pio_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nios_sys_pio_initiator.sv
// Avalon-MM initiator issuing queued commands to zero-wait PIO slaves.
// Define NIOS_SYS_PIO_INITIATOR_VERIFY_EN to add a read-back check after every write.
module nios_sys_pio_initiator
  import nios_sys_pio_pkg::*;
#(
  parameter int               ADDR_W      = CMD_ADDR_W,
  parameter int               DATA_W      = CMD_DATA_W,
  parameter int               FIFO_DEPTH  = 4,
  parameter int               GAP_CYCLES  = 0,
  parameter logic [DATA_W-1:0] VERIFY_MASK = DATA_W'(32'h0000_000F)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic              chipselect,
  output logic              write_n,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              chipselect_q, chipselect_d;
  logic              write_n_q, write_n_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
  logic              rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0] vdata_q, vdata_d;
`endif

  cmd_t cmd_in, head;
  logic fifo_full, fifo_empty, push, pop;
  logic slot_free, verify_next;

  assign cmd_in = {cmd_write, cmd_address, cmd_wdata};
  assign push   = cmd_valid && !fifo_full;

  nios_sys_pio_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (cmd_in),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
  assign verify_next = !write_n_q;
`else
  assign verify_next = 1'b0;
`endif

  // slot_free marks the last cycle of an access/gap stretch; the next
  // command launches straight from it so spacing is exactly GAP_CYCLES.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    chipselect_d = BUS_IDLE_CS;
    write_n_d    = BUS_IDLE_WRITE_N;
    address_d    = BUS_IDLE_ADDR;
    writedata_d  = BUS_IDLE_WDATA;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
    rsp_error_d  = rsp_error_q;
    vdata_d      = vdata_q;
`endif
    pop          = 1'b0;
    slot_free    = 1'b0;

    case (state_q)
      ST_IDLE: slot_free = 1'b1;
      ST_ACCESS: begin
        if (write_n_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = readdata;
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
          rsp_error_d = 1'b0;
`endif
        end
        if (verify_next) begin
          state_d      = ST_VERIFY;
          chipselect_d = 1'b1;
          write_n_d    = 1'b1;
          address_d    = address_q;
        end else if (GAP_CYCLES > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          slot_free = 1'b1;
        end
      end
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
      ST_VERIFY: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = readdata;
        rsp_error_d = |((readdata ^ vdata_q) & VERIFY_MASK);
        if (GAP_CYCLES > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          slot_free = 1'b1;
        end
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) slot_free = 1'b1;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (slot_free) begin
      state_d   = ST_IDLE;
      gap_cnt_d = '0;
      if (!fifo_empty) begin
        pop          = 1'b1;
        state_d      = ST_ACCESS;
        chipselect_d = 1'b1;
        write_n_d    = !head.write;
        address_d    = head.address;
        writedata_d  = head.write ? head.wdata : BUS_IDLE_WDATA;
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
        vdata_d      = head.wdata;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      chipselect_q <= BUS_IDLE_CS;
      write_n_q    <= BUS_IDLE_WRITE_N;
      address_q    <= BUS_IDLE_ADDR;
      writedata_q  <= BUS_IDLE_WDATA;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
      rsp_error_q  <= 1'b0;
      vdata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      chipselect_q <= chipselect_d;
      write_n_q    <= write_n_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
      rsp_error_q  <= rsp_error_d;
      vdata_q      <= vdata_d;
`endif
    end
  end

  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign chipselect = chipselect_q;
  assign write_n    = write_n_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
  assign rsp_error  = rsp_error_q;
`else
  assign rsp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_nios_sys_pio_initiator.sv
// Randomized bench: three initiators (GAP_CYCLES 0/3/15) share one command
// stream and are compared each cycle against an access-schedule model.
`timescale 1ns/1ps
module tb_nios_sys_pio_initiator;

  localparam int NI    = 3;
  localparam int DEPTH = 4;
  localparam int HMAX  = 1024;
  localparam logic [31:0] MASK = 32'h0000_000F;
`ifdef NIOS_SYS_PIO_INITIATOR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 3 : 15;
  endfunction

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_write;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_wdata;
  logic [31:0] slave_reg [4];

  logic        cmd_ready  [NI];
  logic        rsp_valid  [NI];
  logic [31:0] rsp_rdata  [NI];
  logic        rsp_error  [NI];
  logic        busy       [NI];
  logic        chipselect [NI];
  logic        write_n    [NI];
  logic [1:0]  address    [NI];
  logic [31:0] writedata  [NI];
  logic [31:0] readdata   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign readdata[g] = slave_reg[address[g]];
    nios_sys_pio_initiator #(
      .ADDR_W(2), .DATA_W(32), .FIFO_DEPTH(DEPTH),
      .GAP_CYCLES(gap_of(g)), .VERIFY_MASK(MASK)
    ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[g]),
      .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_error(rsp_error[g]),
      .busy(busy[g]), .chipselect(chipselect[g]), .write_n(write_n[g]),
      .address(address[g]), .writedata(writedata[g]), .readdata(readdata[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  // Model: each accepted command is scheduled to the cycle its access will
  // occupy the bus; everything else follows from that schedule.
  typedef struct packed {
    int          start;
    logic        write;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } acc_t;

  acc_t hist [NI][HMAX];
  int   n_acc   [NI];
  int   lo      [NI];
  int   free_at [NI];
  int   cyc = 0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      n_acc[i] = 0; lo[i] = 0; free_at[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!reset_n) begin
          lo[i] = n_acc[i];
          free_at[i] = 0;
        end else begin
          logic        e_cs, e_wn, e_rv, e_re;
          logic [1:0]  e_addr;
          logic [31:0] e_wd, e_rd;
          int occ, rsp_at;
          e_cs = 0; e_wn = 1; e_addr = 0; e_wd = 0; e_rv = 0; e_rd = 0; e_re = 0; occ = 0;
          while (lo[i] < n_acc[i] && hist[i][lo[i]].start + 2 < cyc) lo[i]++;
          for (int k = lo[i]; k < n_acc[i]; k++) begin
            acc_t a;
            a = hist[i][k];
            if (a.start > cyc) occ++;
            if (a.start == cyc) begin
              e_cs = 1; e_wn = !a.write; e_addr = a.addr; e_wd = a.write ? a.wdata : 32'h0;
            end
            if (VERIFY && a.write && a.start + 1 == cyc) begin
              e_cs = 1; e_wn = 1; e_addr = a.addr; e_wd = 0;
            end
            rsp_at = a.write ? (VERIFY ? a.start + 2 : -1) : a.start + 1;
            if (rsp_at == cyc) begin
              e_rv = 1; e_rd = a.rexp;
              e_re = a.write && (((a.rexp ^ a.wdata) & MASK) != 0);
            end
          end
          check($sformatf("cs%0d", i),    chipselect[i], e_cs);
          check($sformatf("wn%0d", i),    write_n[i],    e_wn);
          check($sformatf("addr%0d", i),  address[i],    e_addr);
          check($sformatf("wdata%0d", i), writedata[i],  e_wd);
          check($sformatf("rspv%0d", i),  rsp_valid[i],  e_rv);
          check($sformatf("busy%0d", i),  busy[i],       (occ > 0) || (cyc < free_at[i]));
          check($sformatf("rdy%0d", i),   cmd_ready[i],  occ < DEPTH);
          if (e_rv) begin
            check($sformatf("rdata%0d", i), rsp_rdata[i], e_rd);
            check($sformatf("rerr%0d", i),  rsp_error[i], e_re);
          end
          if (cmd_valid && occ < DEPTH && n_acc[i] < HMAX) begin
            acc_t a;
            a.start = (cyc + 2 > free_at[i]) ? cyc + 2 : free_at[i];
            a.write = cmd_write;
            a.addr  = cmd_address;
            a.wdata = cmd_wdata;
            a.rexp  = slave_reg[cmd_address];
            hist[i][n_acc[i]] = a;
            n_acc[i]++;
            free_at[i] = a.start + 1 + ((VERIFY && cmd_write) ? 1 : 0) + gap_of(i);
          end
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit w, input logic [1:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_cs%0d", tag, i),   chipselect[i], 1'b0);
      check($sformatf("%s_wn%0d", tag, i),   write_n[i],    1'b1);
      check($sformatf("%s_addr%0d", tag, i), address[i],    2'd0);
      check($sformatf("%s_wd%0d", tag, i),   writedata[i],  32'h0);
      check($sformatf("%s_rv%0d", tag, i),   rsp_valid[i],  1'b0);
      check($sformatf("%s_busy%0d", tag, i), busy[i],       1'b0);
      check($sformatf("%s_rdy%0d", tag, i),  cmd_ready[i],  1'b1);
    end
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_wdata = '0;
    for (int k = 0; k < 4; k++) slave_reg[k] = 32'h0;

    repeat (3) tick();
    check_idle("rst");
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_rdata%0d", i), rsp_rdata[i], 32'h0);
      check($sformatf("rst_rerr%0d", i),  rsp_error[i], 1'b0);
    end
    reset_n = 1'b1;

    send(1'b1, 2'd0, 32'h5);
    idle(25);

    slave_reg[1] = 32'h0000_000A;
    send(1'b0, 2'd1, 32'hDEAD_BEEF);
    idle(25);

    slave_reg[2] = 32'h6;
    slave_reg[3] = 32'h3;
    send(1'b1, 2'd2, 32'h7);
    idle(25);
    send(1'b1, 2'd3, 32'h3);
    idle(25);

    // Six back-to-back offers; the GAP_CYCLES=15 instance fills and refuses.
    for (int k = 0; k < 6; k++) send(k[0], 2'(k), 32'h100 + 32'(k));
    idle(120);

    send(1'b1, 2'd0, 32'h11);
    send(1'b1, 2'd1, 32'h22);
    idle(45);

    for (int k = 0; k < 4; k++) slave_reg[k] = $urandom;
    for (int n = 0; n < 400; n++) begin
      cmd_valid   = ($urandom_range(0, 1) == 1);
      cmd_write   = ($urandom_range(0, 1) == 1);
      cmd_address = 2'($urandom_range(0, 3));
      cmd_wdata   = (($urandom_range(0, 1) == 1) ? slave_reg[cmd_address] : $urandom);
      tick();
    end
    idle(120);

    for (int k = 0; k < 5; k++) send(1'b0, 2'(k), 32'h0);
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      if (chipselect[2]) seen = 1'b1;
      else tick();
    end
    check("rst_wait", seen, 1'b1);
    reset_n = 1'b0;
    #1;
    check_idle("midrst");
    tick();
    tick();
    reset_n = 1'b1;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
